cdb_arbiter: RTL and testbench

//  Downstream of the ALU/load/branch reservation stations: collects their completed results
//  (robNum + data) and drives the two common data bus lanes (CDBiscast/CDBiscast2).
//  Per-source FIFOs absorb collisions. Round-robin grant keeps one busy unit from starving another.

---
 rtl/cdb_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects completed results from the reservation stations and
// broadcasts them on the common data bus.
//  - Each source has its own small FIFO of {rob tag, data}. src_ready depends
//    only on that FIFO's occupancy.
//  - Each cycle a round-robin scan of the registered FIFO state grants up to
//    two sources (lane 0, then lane 1). The lane registers load the FIFO heads
//    on the edge where those entries are popped.
//  - Optional feature macro: CDB_LANE2_EN. When it is defined, lane 1 is live
//    and two grants per cycle are possible. When it is undefined, only lane 0
//    is driven and the lane 1 outputs are tied to idle values.
//
// Handshake: a source result transfers on a rising edge where src_valid[i] and
// src_ready[i] are both high. src_ready[i] is high whenever FIFO i is not full.
// A transferred result whose tag equals INVALID_TAG is accepted and dropped.
// CDB lanes have no back-pressure. A lane valid stays high for exactly one
// cycle per result.
module cdb_arbiter #(
    parameter int          NUM_SRC     = 3,
    parameter int          FIFO_DEPTH  = 2,
    parameter logic [5:0]  INVALID_TAG = 6'b010000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [6*NUM_SRC-1:0]    src_rob,
    input  logic [32*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic                    CDBiscast,
    output logic [5:0]              CDBrobNum,
    output logic [31:0]             CDBdata,
    output logic                    CDBiscast2,
    output logic [5:0]              CDBrobNum2,
    output logic [31:0]             CDBdata2
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Per-source FIFO storage and bookkeeping
    logic [5:0]    q_rob  [NUM_SRC][FIFO_DEPTH];
    logic [31:0]   q_data [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr [NUM_SRC];
    logic [PW-1:0] rd_ptr [NUM_SRC];
    logic [CW-1:0] count  [NUM_SRC];

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] not_empty;

    // Round-robin pointer: first source examined by the next grant scan
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_next;
    logic [SW-1:0] last_idx;

    // Lane 0 grant
    logic          g0_v;
    logic [SW-1:0] g0_idx;
    logic [5:0]    g0_rob;
    logic [31:0]   g0_data;

`ifdef CDB_LANE2_EN
    // Lane 1 grant
    logic          g1_v;
    logic [SW-1:0] g1_idx;
    logic [5:0]    g1_rob;
    logic [31:0]   g1_data;
`endif

    // Ready is purely occupancy based; invalid-tag pushes handshake but never write
    always_comb begin
        src_ready = '0;
        push      = '0;
        not_empty = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count[i] != CW'(FIFO_DEPTH));
            push[i]      = src_valid[i] && src_ready[i] &&
                           (src_rob[6*i +: 6] != INVALID_TAG);
            not_empty[i] = (count[i] != '0);
        end
    end

    // Round-robin scan: first non-empty source from rr_ptr gets lane 0,
    // the second (if lane 1 exists) gets lane 1
    always_comb begin
        logic [SW-1:0] scan_idx;
        g0_v     = 1'b0;
        g0_idx   = '0;
        scan_idx = '0;
`ifdef CDB_LANE2_EN
        g1_v     = 1'b0;
        g1_idx   = '0;
`endif
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = SW'((int'(rr_ptr) + k) % NUM_SRC);
            if (not_empty[scan_idx]) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_idx = scan_idx;
                end
`ifdef CDB_LANE2_EN
                else if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = scan_idx;
                end
`endif
            end
        end
    end

    // Pop vector, FIFO head selection and the next round-robin pointer
    always_comb begin
        pop      = '0;
        last_idx = g0_idx;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = g0_v && (g0_idx == SW'(i));
`ifdef CDB_LANE2_EN
            pop[i] = pop[i] || (g1_v && (g1_idx == SW'(i)));
`endif
        end
`ifdef CDB_LANE2_EN
        if (g1_v) begin
            last_idx = g1_idx;
        end
`endif
        if (!g0_v) begin
            rr_next = rr_ptr;
        end else if (last_idx == SW'(NUM_SRC - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = last_idx + SW'(1);
        end
        g0_rob  = q_rob[g0_idx][rd_ptr[g0_idx]];
        g0_data = q_data[g0_idx][rd_ptr[g0_idx]];
`ifdef CDB_LANE2_EN
        g1_rob  = q_rob[g1_idx][rd_ptr[g1_idx]];
        g1_data = q_data[g1_idx][rd_ptr[g1_idx]];
`endif
    end

    // FIFO payload storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                q_rob[i][wr_ptr[i]]  <= src_rob[6*i +: 6];
                q_data[i][wr_ptr[i]] <= src_data[32*i +: 32];
            end
        end
    end

    // FIFO pointers and occupancy; reset (also the squash) empties every FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Lane 0 output register and round-robin pointer update
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= '0;
            CDBiscast <= 1'b0;
            CDBrobNum <= INVALID_TAG;
            CDBdata   <= '0;
        end else begin
            rr_ptr    <= rr_next;
            CDBiscast <= g0_v;
            CDBrobNum <= g0_v ? g0_rob  : INVALID_TAG;
            CDBdata   <= g0_v ? g0_data : 32'd0;
        end
    end

`ifdef CDB_LANE2_EN
    // Lane 1 output register, loaded from the second granted source
    always_ff @(posedge clock) begin
        if (reset) begin
            CDBiscast2 <= 1'b0;
            CDBrobNum2 <= INVALID_TAG;
            CDBdata2   <= '0;
        end else begin
            CDBiscast2 <= g1_v;
            CDBrobNum2 <= g1_v ? g1_rob  : INVALID_TAG;
            CDBdata2   <= g1_v ? g1_data : 32'd0;
        end
    end
`else
    // Single-lane build: lane 1 permanently idle
    assign CDBiscast2 = 1'b0;
    assign CDBrobNum2 = INVALID_TAG;
    assign CDBdata2   = 32'd0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Expectations follow the lane build
// selected by CDB_LANE2_EN (single lane when undefined).
module tb_cdb_arbiter;

  localparam logic [5:0] INV = 6'd16;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  src_valid;
  logic [17:0] src_rob;
  logic [95:0] src_data;
  logic [2:0]  src_ready;
  logic        CDBiscast;
  logic [5:0]  CDBrobNum;
  logic [31:0] CDBdata;
  logic        CDBiscast2;
  logic [5:0]  CDBrobNum2;
  logic [31:0] CDBdata2;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [37:0] exp_q [3][$];
  int          cnt_model [3];

  cdb_arbiter #(
    .NUM_SRC    (3),
    .FIFO_DEPTH (2),
    .INVALID_TAG(6'b010000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .src_valid (src_valid),
    .src_rob   (src_rob),
    .src_data  (src_data),
    .src_ready (src_ready),
    .CDBiscast (CDBiscast),
    .CDBrobNum (CDBrobNum),
    .CDBdata   (CDBdata),
    .CDBiscast2(CDBiscast2),
    .CDBrobNum2(CDBrobNum2),
    .CDBdata2  (CDBdata2)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] dat(input logic [5:0] r);
    return 32'hD000_0000 | {26'd0, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [5:0] r0, input logic [5:0] r1,
                       input logic [5:0] r2);
    src_valid = v;
    src_rob   = {r2, r1, r0};
    src_data  = {dat(r2), dat(r1), dat(r0)};
  endtask

  task automatic chk_l0(input string nm, input logic v, input logic [5:0] r, input logic [31:0] d);
    chk({nm, "_v0"}, 64'(CDBiscast), 64'(v));
    chk({nm, "_rob0"}, 64'(CDBrobNum), 64'(r));
    chk({nm, "_data0"}, 64'(CDBdata), 64'(d));
  endtask

  task automatic chk_l1(input string nm, input logic v, input logic [5:0] r, input logic [31:0] d);
    chk({nm, "_v1"}, 64'(CDBiscast2), 64'(v));
    chk({nm, "_rob1"}, 64'(CDBrobNum2), 64'(r));
    chk({nm, "_data1"}, 64'(CDBdata2), 64'(d));
  endtask

  task automatic chk_idle(input string nm);
    chk_l0(nm, 1'b0, INV, 32'd0);
    chk_l1(nm, 1'b0, INV, 32'd0);
  endtask

  // scoreboard: a broadcast tag identifies its source via tag[5:3]
  task automatic sb_take(input logic [5:0] r, input logic [31:0] d);
    int s;
    s = int'(r[5:3]) - 4;
    if (s < 0 || s > 2) begin
      chk("t4_src", 64'(r), 64'(6'd32));
    end else if (exp_q[s].size() == 0) begin
      chk("t4_unexpected", 64'(r), 64'(INV));
    end else begin
      chk("t4_order", 64'({r, d}), 64'(exp_q[s].pop_front()));
      cnt_model[s]--;
    end
  endtask

  initial begin
    int sent;
    int left [3];
    int base [3];
    logic [2:0] v;
    logic [5:0] r [3];

    // reset state
    reset = 1'b1;
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    tick();
    chk_idle("rst");
    chk("rst_ready", 64'(src_ready), 64'(3'b111));
    reset = 1'b0;

    // reset mid-stream, with pushes on the reset edge itself
    drive(3'b110, 6'd0, 6'd20, 6'd21);
    tick();
    drive(3'b111, 6'd22, 6'd23, 6'd24);
    tick();
    drive(3'b001, 6'd25, 6'd0, 6'd0);
    tick();
    reset = 1'b1;
    drive(3'b111, 6'd26, 6'd27, 6'd28);
    tick();
    reset = 1'b0;
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    chk_idle("t1_after_rst");
    chk("t1_ready", 64'(src_ready), 64'(3'b111));
    tick();
    chk_idle("t1_flush_a");
    tick();
    chk_idle("t1_flush_b");

    // single result from src0
    src_valid = 3'b001;
    src_rob   = {6'd0, 6'd0, 6'd5};
    src_data  = {32'd0, 32'd0, 32'h0000_00AA};
    tick();
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    chk_idle("t2_n");
    tick();
    chk_l0("t2_n1", 1'b1, 6'd5, 32'h0000_00AA);
    chk_l1("t2_n1", 1'b0, INV, 32'd0);
    tick();
    chk_idle("t2_n2");

    // three simultaneous pushes with rr_ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    chk_idle("t3_c0");
    tick();
`ifdef CDB_LANE2_EN
    chk_l0("t3_c1", 1'b1, 6'd1, dat(6'd1));
    chk_l1("t3_c1", 1'b1, 6'd2, dat(6'd2));
    tick();
    chk_l0("t3_c2", 1'b1, 6'd3, dat(6'd3));
    chk_l1("t3_c2", 1'b0, INV, 32'd0);
    tick();
    chk_idle("t3_c3");
`else
    chk_l0("t3_c1", 1'b1, 6'd1, dat(6'd1));
    chk_l1("t3_c1", 1'b0, INV, 32'd0);
    tick();
    chk_l0("t3_c2", 1'b1, 6'd2, dat(6'd2));
    chk_l1("t3_c2", 1'b0, INV, 32'd0);
    tick();
    chk_l0("t3_c3", 1'b1, 6'd3, dat(6'd3));
    chk_l1("t3_c3", 1'b0, INV, 32'd0);
`endif
    // rr_ptr must be back at 0: src0 wins over src2
    drive(3'b101, 6'd10, 6'd0, 6'd12);
    tick();
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
`ifdef CDB_LANE2_EN
    chk_l0("t3_rr", 1'b1, 6'd10, dat(6'd10));
    chk_l1("t3_rr", 1'b1, 6'd12, dat(6'd12));
    tick();
    chk_idle("t3_rr_end");
`else
    chk_l0("t3_rr", 1'b1, 6'd10, dat(6'd10));
    chk_l1("t3_rr", 1'b0, INV, 32'd0);
    tick();
    chk_l0("t3_rr2", 1'b1, 6'd12, dat(6'd12));
    chk_l1("t3_rr2", 1'b0, INV, 32'd0);
`endif
    tick();
    chk_idle("t3_quiet");

    // invalid-tag push is accepted but never broadcast
    drive(3'b010, 6'd0, INV, 6'd0);
    chk("t5_ready", 64'(src_ready[1]), 64'(1'b1));
    tick();
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    chk_idle("t5_a");
    chk("t5_ready_after", 64'(src_ready), 64'(3'b111));
    tick();
    chk_idle("t5_b");
    tick();
    chk_idle("t5_c");

    // all sources pushing every cycle they can; scoreboard per source
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      cnt_model[i] = 0;
    end
    left[0] = 3; left[1] = 4; left[2] = 4;
    base[0] = 32; base[1] = 40; base[2] = 48;
    sent = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (CDBiscast) sb_take(CDBrobNum, CDBdata);
      if (CDBiscast2) sb_take(CDBrobNum2, CDBdata2);
      if (CDBiscast && CDBiscast2)
        chk("t4_distinct", 64'(CDBrobNum[5:3] != CDBrobNum2[5:3]), 64'(1'b1));
`ifndef CDB_LANE2_EN
      chk("t4_lane1_off", 64'(CDBiscast2), 64'(1'b0));
`endif
      for (int i = 0; i < 3; i++)
        chk("t4_ready", 64'(src_ready[i]), 64'(cnt_model[i] < 2));
      if (sent == 11 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0)
        break;
      v = 3'b000;
      for (int i = 0; i < 3; i++) begin
        r[i] = 6'd0;
        if (left[i] > 0 && src_ready[i]) begin
          v[i] = 1'b1;
          r[i] = 6'(base[i]);
          exp_q[i].push_back({r[i], dat(r[i])});
          cnt_model[i]++;
          base[i]++;
          left[i]--;
          sent++;
        end
      end
      drive(v, r[0], r[1], r[2]);
      tick();
    end
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    chk("t4_sent", 64'(sent), 64'(11));
    chk("t4_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
    tick();
    chk_idle("t4_end");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
